// File: rtl/matmul_pkg.sv
// Shared types and default sizing for the matmul job arbiter.
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        RESP
    } state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_M          = 8;
    localparam int DEF_N          = 8;
    localparam int DEF_P          = 8;
    localparam int DEF_NUM_REQ    = 2;
    localparam int DEF_TIMEOUT    = 1024;
    localparam int JOB_COUNT_W    = 16;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matmul_arbiter_rr.sv
// rr_arbiter: one-hot grant to the lowest requesting index at or after pointer, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] grant
);

    logic found;

    // First pass covers indices at/after the pointer, second pass wraps to the bottom.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (i >= 32'(pointer))) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/matmul_arbiter.sv
// Round-robin front end sharing one matrix multiplier among NUM_REQ requesters.
// Optional watchdog on the multiplier wait: define MATMUL_TIMEOUT_EN.
module matmul_arbiter
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int M              = DEF_M,
    parameter int N              = DEF_N,
    parameter int P              = DEF_P,
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*M*N*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*N*P*DATA_WIDTH-1:0] req_b,
    output logic                            mm_start,
    output logic [M*N*DATA_WIDTH-1:0]       mm_matrix_a,
    output logic [N*P*DATA_WIDTH-1:0]       mm_matrix_b,
    input  logic                            mm_done,
    input  logic [M*P*DATA_WIDTH-1:0]       mm_result_c,
    output logic [NUM_REQ-1:0]              rsp_valid,
    input  logic [NUM_REQ-1:0]              rsp_ready,
    output logic [M*P*DATA_WIDTH-1:0]       rsp_result,
    output logic                            rsp_error,
    output logic                            busy,
    output logic [JOB_COUNT_W-1:0]          job_count
);

    localparam int A_W   = M*N*DATA_WIDTH;
    localparam int B_W   = N*P*DATA_WIDTH;
    localparam int PTR_W = ptr_width(NUM_REQ);

    state_t             state;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] owner;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   next_ptr;
    logic               done_q;
    logic               done_rise;
    logic [A_W-1:0]     sel_a;
    logic [B_W-1:0]     sel_b;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req     (req_valid),
        .pointer (ptr),
        .grant   (grant)
    );

    assign req_ready = (state == IDLE) ? grant : '0;
    assign busy      = (state != IDLE);
    assign done_rise = mm_done & ~done_q;

    always_comb begin
        sel_a    = '0;
        sel_b    = '0;
        next_ptr = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a    = req_a[i*A_W +: A_W];
                sel_b    = req_b[i*B_W +: B_W];
                next_ptr = (i + 1 == NUM_REQ) ? '0 : PTR_W'(i + 1);
            end
        end
    end

`ifdef MATMUL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
`else
    // No watchdog: WAIT is unbounded and no error can be reported.
    assign rsp_error = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mm_start    <= 1'b0;
            mm_matrix_a <= '0;
            mm_matrix_b <= '0;
            owner       <= '0;
            ptr         <= '0;
            done_q      <= 1'b0;
            rsp_valid   <= '0;
            rsp_result  <= '0;
            job_count   <= '0;
`ifdef MATMUL_TIMEOUT_EN
            rsp_error   <= 1'b0;
            wait_cnt    <= '0;
`endif
        end else begin
            done_q   <= mm_done;
            mm_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (|(req_valid & req_ready)) begin
                        mm_matrix_a <= sel_a;
                        mm_matrix_b <= sel_b;
                        owner       <= grant;
                        ptr         <= next_ptr;
                        mm_start    <= 1'b1;
                        state       <= START;
`ifdef MATMUL_TIMEOUT_EN
                        rsp_error   <= 1'b0;
`endif
                    end
                end
                START: begin
                    state <= WAIT;
`ifdef MATMUL_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                WAIT: begin
                    // Only a fresh rising edge counts; a level left over from the last job is ignored.
                    if (done_rise) begin
                        rsp_result <= mm_result_c;
                        rsp_valid  <= owner;
                        state      <= RESP;
                    end
`ifdef MATMUL_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_result <= '0;
                        rsp_valid  <= owner;
                        rsp_error  <= 1'b1;
                        state      <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end
                RESP: begin
                    if (|(rsp_ready & owner)) begin
                        rsp_valid <= '0;
                        job_count <= job_count + JOB_COUNT_W'(1);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_arbiter.sv
// Directed, table-driven bench for matmul_arbiter with a behavioural multiplier on the mm_* side.
module tb_matmul_arbiter;

    localparam int DW  = 8;
    localparam int M   = 8;
    localparam int N   = 8;
    localparam int P   = 8;
    localparam int NR  = 2;
    localparam int A_W = M*N*DW;
    localparam int B_W = N*P*DW;
    localparam int C_W = M*P*DW;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*A_W-1:0] req_a;
    logic [NR*B_W-1:0] req_b;
    logic            mm_start;
    logic [A_W-1:0]  mm_matrix_a;
    logic [B_W-1:0]  mm_matrix_b;
    logic            mm_done;
    logic [C_W-1:0]  mm_result_c;
    logic [NR-1:0]   rsp_valid;
    logic [NR-1:0]   rsp_ready;
    logic [C_W-1:0]  rsp_result;
    logic            rsp_error;
    logic            busy;
    logic [15:0]     job_count;

    matmul_arbiter #(
        .DATA_WIDTH     (DW),
        .M              (M),
        .N              (N),
        .P              (P),
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .mm_start    (mm_start),
        .mm_matrix_a (mm_matrix_a),
        .mm_matrix_b (mm_matrix_b),
        .mm_done     (mm_done),
        .mm_result_c (mm_result_c),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_error   (rsp_error),
        .busy        (busy),
        .job_count   (job_count)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned exp_jobs = 0;

    logic [A_W-1:0] a_op [NR];
    logic [B_W-1:0] b_op [NR];

    // mode: 0 = done pulse, 1 = done level, 2 = stale done level carried into WAIT
    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  grant;
        int unsigned lat;
        int unsigned mode;
        int unsigned hold;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [C_W-1:0] act, input logic [C_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [C_W-1:0] matmul(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
        logic [C_W-1:0] c;
        c = '0;
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < P; j++) begin
                int acc;
                acc = 0;
                for (int k = 0; k < N; k++)
                    acc += int'(a[(i*N+k)*DW +: DW]) * int'(b[(k*P+j)*DW +: DW]);
                c[(i*P+j)*DW +: DW] = acc[DW-1:0];
            end
        end
        return c;
    endfunction

    task automatic run_job(input logic [1:0] valid, input logic [1:0] grant,
                           input int unsigned lat, input int unsigned mode, input int unsigned hold);
        int unsigned    g;
        logic [C_W-1:0] gold;
        g    = (grant == 2'b10) ? 1 : 0;
        gold = matmul(a_op[g], b_op[g]);
        if (mode == 2) begin
            mm_done     = 1'b1;
            mm_result_c = '1;
        end
        req_valid = valid;
        #1;
        check("req_ready_grant", C_W'(req_ready), C_W'(grant));
        tick();
        check("mm_start_high", C_W'(mm_start), C_W'(1));
        check("req_ready_busy", C_W'(req_ready), C_W'(0));
        check("busy_high", C_W'(busy), C_W'(1));
        check("mm_matrix_a", C_W'(mm_matrix_a), C_W'(a_op[g]));
        check("mm_matrix_b", C_W'(mm_matrix_b), C_W'(b_op[g]));
        tick();
        check("mm_start_low", C_W'(mm_start), C_W'(0));
        for (int unsigned i = 0; i < lat; i++) begin
            tick();
            check("no_early_rsp", C_W'(rsp_valid), C_W'(0));
        end
        if (mode == 2) begin
            mm_done = 1'b0;
            tick();
        end
        mm_done     = 1'b1;
        mm_result_c = matmul(mm_matrix_a, mm_matrix_b);
        tick();
        if (mode == 0) mm_done = 1'b0;
        check("rsp_valid_owner", C_W'(rsp_valid), C_W'(grant));
        check("rsp_result", rsp_result, gold);
        check("rsp_error_clear", C_W'(rsp_error), C_W'(0));
        for (int unsigned h = 0; h < hold; h++) begin
            rsp_ready = ~grant;
            tick();
            check("rsp_valid_hold", C_W'(rsp_valid), C_W'(grant));
            check("rsp_result_hold", rsp_result, gold);
            check("no_grant_in_resp", C_W'(req_ready), C_W'(0));
        end
        rsp_ready = grant;
        tick();
        rsp_ready = '0;
        mm_done   = 1'b0;
        req_valid = '0;
        exp_jobs++;
        check("rsp_valid_drop", C_W'(rsp_valid), C_W'(0));
        check("job_count", C_W'(job_count), C_W'(exp_jobs));
        check("busy_idle", C_W'(busy), C_W'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{2'b01, 2'b01, 3, 0, 1};
        vecs[1] = '{2'b10, 2'b10, 0, 1, 1};
        vecs[2] = '{2'b11, 2'b01, 2, 0, 1};
        vecs[3] = '{2'b11, 2'b10, 3, 2, 1};
        vecs[4] = '{2'b11, 2'b01, 0, 0, 20};
        vecs[5] = '{2'b11, 2'b10, 4, 1, 1};
        vecs[6] = '{2'b10, 2'b10, 1, 0, 1};
        vecs[7] = '{2'b01, 2'b01, 2, 1, 1};

        for (int r = 0; r < NR; r++) begin
            for (int e = 0; e < M*N; e++) a_op[r][e*DW +: DW] = 8'((e + 5*r) % 16);
            for (int e = 0; e < N*P; e++) b_op[r][e*DW +: DW] = 8'((e + 1 + 7*r) % 16);
        end
        req_a       = {a_op[1], a_op[0]};
        req_b       = {b_op[1], b_op[0]};
        rst         = 1'b1;
        req_valid   = '0;
        rsp_ready   = '0;
        mm_done     = 1'b0;
        mm_result_c = '0;
        tick();
        tick();
        check("rst_busy", C_W'(busy), C_W'(0));
        check("rst_rsp_valid", C_W'(rsp_valid), C_W'(0));
        check("rst_job_count", C_W'(job_count), C_W'(0));
        check("rst_mm_start", C_W'(mm_start), C_W'(0));
        check("rst_rsp_error", C_W'(rsp_error), C_W'(0));
        check("rst_matrix_a", C_W'(mm_matrix_a), C_W'(0));
        rst = 1'b0;
        tick();

        for (int unsigned v = 0; v < 8; v++)
            run_job(vecs[v].valid, vecs[v].grant, vecs[v].lat, vecs[v].mode, vecs[v].hold);

        // Reset while waiting on the multiplier abandons the job.
        req_valid = 2'b01;
        tick();
        req_valid = '0;
        tick();
        tick();
        check("wait_busy", C_W'(busy), C_W'(1));
        rst = 1'b1;
        #1;
        check("rstw_busy", C_W'(busy), C_W'(0));
        check("rstw_rsp_valid", C_W'(rsp_valid), C_W'(0));
        check("rstw_job_count", C_W'(job_count), C_W'(0));
        check("rstw_matrix_a", C_W'(mm_matrix_a), C_W'(0));
        exp_jobs = 0;
        tick();
        rst = 1'b0;
        tick();
        run_job(2'b01, 2'b01, 2, 0, 1);

        // Multiplier never answers.
        req_valid = 2'b10;
        #1;
        check("req_ready_wd", C_W'(req_ready), C_W'(2'b10));
        tick();
        req_valid = '0;
        tick();
`ifdef MATMUL_TIMEOUT_EN
        for (int unsigned i = 0; i < 15; i++) tick();
        check("wd_not_yet", C_W'(rsp_valid), C_W'(0));
        tick();
        check("wd_rsp_valid", C_W'(rsp_valid), C_W'(2'b10));
        check("wd_rsp_error", C_W'(rsp_error), C_W'(1));
        check("wd_rsp_result", rsp_result, C_W'(0));
`else
        for (int unsigned i = 0; i < 40; i++) tick();
        check("unbounded_busy", C_W'(busy), C_W'(1));
        check("unbounded_no_rsp", C_W'(rsp_valid), C_W'(0));
        check("unbounded_no_err", C_W'(rsp_error), C_W'(0));
        mm_done     = 1'b1;
        mm_result_c = matmul(mm_matrix_a, mm_matrix_b);
        tick();
        mm_done = 1'b0;
        check("late_rsp_valid", C_W'(rsp_valid), C_W'(2'b10));
        check("late_rsp_result", rsp_result, matmul(a_op[1], b_op[1]));
`endif
        rsp_ready = 2'b10;
        tick();
        rsp_ready = '0;
        exp_jobs++;
        check("wd_job_count", C_W'(job_count), C_W'(exp_jobs));
`ifdef MATMUL_TIMEOUT_EN
        check("wd_error_held", C_W'(rsp_error), C_W'(1));
`endif
        run_job(2'b01, 2'b01, 1, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matmul_arbiter.md
MATMUL_ARBITER -- requirements
Module: matmul_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the element width.
REQ-002 SHALL have parameters M, N and P, each default 8, meaning A is MxN, B is NxP and C is MxP.
REQ-003 SHALL have parameter NUM_REQ, default 2, meaning the number of requesters (2..4).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the watchdog limit.
REQ-005 SHALL have port clk, input, width 1: the single clock.
REQ-006 SHALL have port rst, input, width 1: reset, asynchronous and active-high.
REQ-007 SHALL have port req_valid, input, width NUM_REQ: per-requester job request.
REQ-008 SHALL have port req_ready, output, width NUM_REQ: per-requester job accept.
REQ-009 SHALL have port req_a, input, width NUM_REQ*M*N*DATA_WIDTH: packed A operands, requester r at slice r.
REQ-010 SHALL have port req_b, input, width NUM_REQ*N*P*DATA_WIDTH: packed B operands.
REQ-011 SHALL have port mm_start, output, width 1: start pulse to the shared multiplier.
REQ-012 SHALL have port mm_matrix_a, output, width M*N*DATA_WIDTH: registered A sent to the multiplier.
REQ-013 SHALL have port mm_matrix_b, output, width N*P*DATA_WIDTH: registered B sent to the multiplier.
REQ-014 SHALL have port mm_done, input, width 1: multiplier completion; may be a level or a pulse.
REQ-015 SHALL have port mm_result_c, input, width M*P*DATA_WIDTH: multiplier result.
REQ-016 SHALL have port rsp_valid, output, width NUM_REQ: result available to the granted requester.
REQ-017 SHALL have port rsp_ready, input, width NUM_REQ: requester accepts the result.
REQ-018 SHALL have port rsp_result, output, width M*P*DATA_WIDTH: captured C.
REQ-019 SHALL have port rsp_error, output, width 1: the job timed out.
REQ-020 SHALL have port busy, output, width 1: the FSM is not in IDLE.
REQ-021 SHALL have port job_count, output, width 16: number of completed responses, wrapping.

Function
REQ-022 SHALL implement FSM states IDLE, START, WAIT and RESP.
REQ-023 In IDLE with any req_valid, SHALL pick a round-robin winner g and drive req_ready = one-hot(g) combinationally; req_ready SHALL be 0 in every other state.
REQ-024 On the cycle where req_valid[g] and req_ready[g] are both high, SHALL latch req_a and req_b slice g into mm_matrix_a and mm_matrix_b, latch g, and move to START.
REQ-025 The round-robin pointer SHALL advance to g+1 mod NUM_REQ after each grant; the lowest index at or after the pointer wins.
REQ-026 In START, SHALL drive mm_start high for exactly 1 cycle, then move to WAIT.
REQ-027 SHALL register done_q = mm_done every cycle; in WAIT, a rising edge (mm_done & ~done_q) SHALL capture mm_result_c into rsp_result and move to RESP.
REQ-028 A done level that is already high on entry to WAIT SHALL be ignored.
REQ-029 In RESP, SHALL hold rsp_valid[g] high until rsp_ready[g] is high; that cycle SHALL increment job_count and return to IDLE.
REQ-030 rsp_ready on non-granted bits SHALL be ignored.
REQ-031 Requests arriving while busy SHALL wait; they SHALL never be dropped and SHALL never be served more than once.
REQ-032 rsp_result and mm_matrix_a/mm_matrix_b SHALL hold their values until next overwritten.

Reset
REQ-033 rst SHALL force, asynchronously: state IDLE, mm_start 0, rsp_valid 0, rsp_error 0, busy 0, job_count 0, pointer 0, done_q 0, and all data registers 0.
REQ-034 Reset mid-job SHALL abandon the job with no response issued.

Configuration
REQ-035 With MATMUL_TIMEOUT_EN defined, a counter SHALL clear on WAIT entry and count each WAIT cycle.
REQ-036 With MATMUL_TIMEOUT_EN defined, the counter reaching TIMEOUT_CYCLES without a done edge SHALL cause a move to RESP with rsp_error 1 and rsp_result 0.
REQ-037 With MATMUL_TIMEOUT_EN defined, rsp_error SHALL clear on the next grant.
REQ-038 Without MATMUL_TIMEOUT_EN, there SHALL be no counter, rsp_error SHALL be tied 0, and WAIT SHALL be unbounded.

Structure
REQ-039 Package matmul_pkg SHALL hold the state enum, the default dimension constants and the job_count width.
REQ-040 The round-robin selection SHALL be one sub-module, rr_arbiter (inputs req and pointer; output one-hot grant).

Verification
REQ-041 Single job: requester 0 sends A = i%16 and B = (i+1)%16 -> one 1-cycle mm_start, and rsp_result equals the golden low-8-bit C; job_count becomes 1.
REQ-042 Contention: req_valid = 2'b11 held for 4 jobs -> grants alternate 0,1,0,1, and each rsp_valid goes only to its owner.
REQ-043 Backpressure: rsp_ready held low for 20 cycles -> rsp_valid and rsp_result stay stable, and no new grant is made.
REQ-044 Stale done: mm_done held high from the previous job into WAIT -> no capture until a fresh rising edge.
REQ-045 Reset in WAIT -> next cycle shows busy 0, rsp_valid 0 and job_count 0; a new request is then served normally.
REQ-046 MATMUL_TIMEOUT_EN with TIMEOUT_CYCLES = 16 and mm_done never asserted -> RESP after 16 WAIT cycles with rsp_error 1 and rsp_result 0.
